// File: rtl/wb_pipe_sram_slave.sv
// Pipelined Wishbone B4 slave: request FIFO feeding an in-order response engine over a word SRAM.
// Define WB_SLAVE_ERR_EN to terminate misaligned or out-of-range accesses with err_o.
module wb_pipe_sram_slave #(
  parameter int unsigned g_addr_width  = 32,
  parameter int unsigned g_data_width  = 32,
  parameter int unsigned g_size_log2   = 10,
  parameter int unsigned g_fifo_depth  = 2,
  parameter int unsigned g_wait_states = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [3:0]              sel_i,
  input  logic [g_addr_width-1:0] adr_i,
  input  logic [g_data_width-1:0] dat_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o,
  output logic                    stall_o,
  output logic [g_data_width-1:0] dat_o
);

  localparam int unsigned PW = (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;
  localparam int unsigned CW = $clog2(g_fifo_depth + 1);
  localparam int unsigned IW = g_size_log2;
  localparam logic [3:0]  WAIT_LOAD = 4'((g_wait_states == 0) ? 0 : g_wait_states - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;

  logic                    q_we  [g_fifo_depth];
  logic [3:0]              q_sel [g_fifo_depth];
  logic [IW-1:0]           q_idx [g_fifo_depth];
  logic [g_data_width-1:0] q_dat [g_fifo_depth];
  logic                    q_ok  [g_fifo_depth];
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;

  logic [g_data_width-1:0] mem [2**g_size_log2];

  logic                    push;
  logic                    pop;
  logic                    req_ok;
  logic                    h_we;
  logic [3:0]              h_sel;
  logic [IW-1:0]           h_idx;
  logic [g_data_width-1:0] h_dat;
  logic                    h_ok;
  logic [g_data_width-1:0] rd_word;
  logic [g_data_width-1:0] hold_dat;
  logic                    hold_rd;
  logic                    hold_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(g_fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef WB_SLAVE_ERR_EN
  assign req_ok = (adr_i[1:0] == 2'b00) && ((adr_i >> (g_size_log2 + 2)) == '0);
`else
  logic unused_adr;
  assign req_ok     = 1'b1;
  assign unused_adr = ^adr_i;
`endif

  // Stall depends only on registered occupancy, so a full FIFO stalls even while popping.
  assign stall_o = (count == CW'(g_fifo_depth));
  assign push    = cyc_i & stb_i & ~stall_o;
  assign pop     = cyc_i & (count != '0) & ((state == S_IDLE) || (state == S_RESP));
  assign rty_o   = 1'b0;

  assign h_we    = q_we[rd_ptr];
  assign h_sel   = q_sel[rd_ptr];
  assign h_idx   = q_idx[rd_ptr];
  assign h_dat   = q_dat[rd_ptr];
  assign h_ok    = q_ok[rd_ptr];
  assign rd_word = mem[h_idx];

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_we[wr_ptr]  <= we_i;
      q_sel[wr_ptr] <= sel_i;
      q_idx[wr_ptr] <= adr_i[IW+1:2];
      q_dat[wr_ptr] <= dat_i;
      q_ok[wr_ptr]  <= req_ok;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!cyc_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Writes commit at pop time, so a cyc_i drop during WAIT still leaves them in memory.
  always_ff @(posedge clk_i) begin
    if (pop && h_we && h_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (h_sel[b]) mem[h_idx][8*b +: 8] <= h_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      hold_dat <= '0;
      hold_rd  <= 1'b0;
      hold_ok  <= 1'b0;
    end else if (!cyc_i) begin
      state <= S_IDLE;
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        S_IDLE, S_RESP: begin
          if (pop) begin
            if (g_wait_states == 0) begin
              state <= S_RESP;
              ack_o <= h_ok;
              err_o <= ~h_ok;
              if (!h_we && h_ok) dat_o <= rd_word;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
              hold_dat <= rd_word;
              hold_rd  <= ~h_we;
              hold_ok  <= h_ok;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_RESP;
            ack_o <= hold_ok;
            err_o <= ~hold_ok;
            if (hold_rd && hold_ok) dat_o <= hold_dat;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_pipe_sram_slave.sv
// Bench for wb_pipe_sram_slave: three instances (different wait states / FIFO depths) exercised in turn
// against a transaction-level model that predicts response edges from acceptance times.
`timescale 1ns/1ps
module tb_wb_pipe_sram_slave;
  localparam int unsigned NDUT = 3;
  localparam int unsigned W_TAB [NDUT] = '{0, 3, 5};
  localparam int unsigned D_TAB [NDUT] = '{2, 2, 4};
  localparam int unsigned SL = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat = '0;
  int          cur = 0;

  logic        cyc_v [NDUT];
  logic        ack_v [NDUT];
  logic        err_v [NDUT];
  logic        rty_v [NDUT];
  logic        stall_v [NDUT];
  logic [31:0] dat_v [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign cyc_v[g] = cyc && (cur == g);
    wb_pipe_sram_slave #(
      .g_addr_width (32),
      .g_data_width (32),
      .g_size_log2  (SL),
      .g_fifo_depth (D_TAB[g]),
      .g_wait_states(W_TAB[g])
    ) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .cyc_i  (cyc_v[g]),
      .stb_i  (stb),
      .we_i   (we),
      .sel_i  (sel),
      .adr_i  (adr),
      .dat_i  (dat),
      .ack_o  (ack_v[g]),
      .err_o  (err_v[g]),
      .rty_o  (rty_v[g]),
      .stall_o(stall_v[g]),
      .dat_o  (dat_v[g])
    );
  end

  // Each accepted request is answered at ack_e = max(accept+1, previous ack_e+1) + W; its access happens at ack_e - W.
  typedef struct {
    bit        we;
    bit [3:0]  sel;
    int unsigned idx;
    bit [31:0] dat;
    bit        ok;
    int        pop_e;
    int        ack_e;
    bit [31:0] rd;
  } req_t;

  req_t        pend[$];
  bit [31:0]   mmem [1024];
  bit [31:0]   winit [16];
  int          resp_t[$];
  int          t = 0;
  int          last_ack = -100;
  bit [31:0]   exp_dat = '0;
  bit          exp_ack = 1'b0, exp_err = 1'b0, exp_stall = 1'b0;
  bit          last_acc = 1'b0;
  bit          stall_seen = 1'b0;
  int          ntests = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, dut %0d)", name, act, exp, t, cur);
    end
  endtask

  function automatic bit model_ok(input bit [31:0] a);
`ifdef WB_SLAVE_ERR_EN
    return (a % 4 == 0) && (a < (32'd4 << SL));
`else
    return 1'b1;
`endif
  endfunction

  function automatic int unsigned model_idx(input bit [31:0] a);
    return (a / 4) % (1 << SL);
  endfunction

  task automatic model_reset();
    pend.delete();
    last_ack  = -100;
    exp_dat   = '0;
    exp_ack   = 1'b0;
    exp_err   = 1'b0;
    exp_stall = 1'b0;
  endtask

  // One clock: update the model for the edge, then compare every output half a cycle later.
  task automatic step();
    int unsigned w = W_TAB[cur];
    int          nq = 0;
    req_t        keep[$];
    last_acc = cyc && stb && !exp_stall;
    @(posedge clk);
    t++;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (!cyc) begin
      pend.delete();
      last_ack = -100;
    end else begin
      if (last_acc) begin
        req_t r;
        r.we    = we;
        r.sel   = sel;
        r.idx   = model_idx(adr);
        r.dat   = dat;
        r.ok    = model_ok(adr);
        r.pop_e = (t + 1 > last_ack + 1) ? t + 1 : last_ack + 1;
        r.ack_e = r.pop_e + int'(w);
        r.rd    = '0;
        last_ack = r.ack_e;
        pend.push_back(r);
      end
      foreach (pend[i]) begin
        if (pend[i].pop_e == t && pend[i].ok) begin
          if (pend[i].we) begin
            for (int b = 0; b < 4; b++)
              if (pend[i].sel[b]) mmem[pend[i].idx][8*b +: 8] = pend[i].dat[8*b +: 8];
          end else begin
            pend[i].rd = mmem[pend[i].idx];
          end
        end
        if (pend[i].ack_e == t) begin
          exp_ack = pend[i].ok;
          exp_err = !pend[i].ok;
          if (!pend[i].we && pend[i].ok) exp_dat = pend[i].rd;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
    end
    foreach (pend[i]) if (pend[i].pop_e > t) nq++;
    exp_stall = (nq == int'(D_TAB[cur]));
    @(negedge clk);
    chk("ack", ack_v[cur], exp_ack);
    chk("err", err_v[cur], exp_err);
    chk("rty", rty_v[cur], 1'b0);
    chk("stall", stall_v[cur], exp_stall);
    chk("dat", dat_v[cur], exp_dat);
    if (ack_v[cur] || err_v[cur]) resp_t.push_back(t);
    if (stall_v[cur]) stall_seen = 1'b1;
  endtask

  task automatic push_req(input bit w_, input bit [3:0] s_, input bit [31:0] a_, input bit [31:0] d_);
    cyc = 1'b1; stb = 1'b1; we = w_; sel = s_; adr = a_; dat = d_;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) break;
    end
    stb = 1'b0;
  endtask

  task automatic drain();
    stb = 1'b0;
    for (int i = 0; i < 100 && pend.size() != 0; i++) step();
    step();
  endtask

  task automatic single(input bit w_, input bit [3:0] s_, input bit [31:0] a_, input bit [31:0] d_,
                        output int lat, output bit [31:0] rdat, output bit got_err);
    lat = -1; rdat = '0; got_err = 1'b0;
    push_req(w_, s_, a_, d_);
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ack_v[cur] || err_v[cur]) begin
        lat = i; rdat = dat_v[cur]; got_err = err_v[cur];
        break;
      end
    end
    chk("latency", lat, 1 + W_TAB[cur]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit [31:0] rd;
    bit er;
    #12;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ack", ack_v[k], 1'b0);
      chk("rst_err", err_v[k], 1'b0);
      chk("rst_rty", rty_v[k], 1'b0);
      chk("rst_stall", stall_v[k], 1'b0);
      chk("rst_dat", dat_v[k], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NDUT; k++) begin
      cyc = 1'b0;
      cur = k;
      model_reset();
      cyc = 1'b1;
      step();

      for (int i = 0; i < 16; i++) begin
        winit[i] = $urandom;
        push_req(1'b1, 4'hF, 32'(i * 4), winit[i]);
      end
      drain();

      single(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, er);
      chk("wr_err", er, 1'b0);
      single(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);
      single(1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, er);
      single(1'b1, 4'h2, 32'h20, 32'h0000AB00, lat, rd, er);
      single(1'b0, 4'hF, 32'h20, 32'h0, lat, rd, er);
      chk("rd_bytelane", rd, 32'h1122AB44);

`ifdef WB_SLAVE_ERR_EN
      single(1'b0, 4'hF, 32'h1002, 32'h0, lat, rd, er);
      chk("misalign_err", er, 1'b1);
      single(1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, er);
      chk("range_err", er, 1'b1);
`else
      single(1'b0, 4'hF, 32'h1000, 32'h0, lat, rd, er);
      chk("alias_err", er, 1'b0);
      chk("alias_word0", rd, winit[0]);
`endif

      resp_t.delete();
      stall_seen = 1'b0;
      for (int i = 0; i < 8; i++) push_req(1'b1, 4'hF, 32'(i * 4), 32'hB000_0000 + 32'(i * 'h111));
      drain();
      repeat (3) step();
      chk("burst_acks", resp_t.size(), 8);
      for (int i = 1; i < resp_t.size(); i++)
        chk("burst_spacing", resp_t[i] - resp_t[i-1], 1 + W_TAB[k]);
      chk("burst_stall", stall_seen, W_TAB[k] > 0);
      for (int i = 0; i < 8; i++) begin
        single(1'b0, 4'hF, 32'(i * 4), 32'h0, lat, rd, er);
        chk("burst_readback", rd, 32'hB000_0000 + 32'(i * 'h111));
      end

      push_req(1'b1, 4'hF, 32'd48, 32'hC0C0_0001);
      push_req(1'b1, 4'hF, 32'd52, 32'hC0C0_0002);
      resp_t.delete();
      cyc = 1'b0;
      repeat (4) step();
      chk("drop_no_resp", resp_t.size(), 0);
      single(1'b0, 4'hF, 32'd52, 32'h0, lat, rd, er);
      chk("drop_discarded", rd, winit[13]);
      single(1'b0, 4'hF, 32'd48, 32'h0, lat, rd, er);
      chk("drop_committed", rd, 32'hC0C0_0001);

      for (int n = 0; n < 300; n++) begin
        bit [31:0] a;
        a = 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 2) * 'h1000);
`ifdef WB_SLAVE_ERR_EN
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
`endif
        cyc = ($urandom_range(0, 39) != 0);
        stb = ($urandom_range(0, 2) != 0);
        we  = $urandom_range(0, 1) == 1;
        sel = 4'($urandom);
        adr = a;
        dat = $urandom;
        step();
      end
      cyc = 1'b1;
      drain();
    end

    single(1'b0, 4'hF, 32'h10, 32'h0, lat, rd, er);
    push_req(1'b0, 4'hF, 32'h20, 32'h0);
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", ack_v[cur], 1'b0);
    chk("midrst_err", err_v[cur], 1'b0);
    chk("midrst_stall", stall_v[cur], 1'b0);
    chk("midrst_dat", dat_v[cur], 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    resp_t.delete();
    repeat (12) step();
    chk("postrst_no_resp", resp_t.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
